// File: rtl/s_32bit_unfold_if.sv
// rtl/s_32bit_unfold_if.sv - fold-link receive stream and frame status signals
interface s_32bit_unfold_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_aa;
  logic [15:0]      in_ahi;
  logic [15:0]      in_bb;
  logic [15:0]      in_bhi;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_a;
  logic [31:0]      out_b;
  logic             out_last;
  logic             frame_done;
  logic [CNT_W-1:0] frame_len;

  modport slave (
    input  in_valid, in_aa, in_ahi, in_bb, in_bhi, in_last, out_ready,
    output in_ready, out_valid, out_a, out_b, out_last, frame_done, frame_len
  );

  modport master (
    output in_valid, in_aa, in_ahi, in_bb, in_bhi, in_last, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_last, frame_done, frame_len
  );
endinterface

// File: rtl/s_32bit_unfold.sv
// rtl/s_32bit_unfold.sv - rebuilds 32-bit a/b words from folded halves through a 2-entry buffer
module s_32bit_unfold #(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  s_32bit_unfold_if.slave   io
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // entry layout: {a[31:0], b[31:0], last}
  logic [64:0]      mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic [1:0]       count_next;
  logic             in_ready_q;
  logic             frame_done_q;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] beat_inc;
  logic [CNT_W-1:0] frame_len_q;
  logic             push;
  logic             pop;
  logic [64:0]      entry;

  always_comb begin
    push     = io.in_valid && in_ready_q;
    pop      = (count != 2'd0) && io.out_ready;
    entry    = {io.in_ahi, io.in_aa ^ io.in_ahi, io.in_bhi, io.in_bb ^ io.in_bhi, io.in_last};
    beat_inc = (beat_cnt == CNT_MAX) ? CNT_MAX : beat_cnt + 1'b1;
    case ({push, pop})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  // in_ready is registered from the next occupancy so out_ready never reaches it combinationally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mem[i] <= '0;
      end
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      count        <= 2'd0;
      in_ready_q   <= 1'b0;
      frame_done_q <= 1'b0;
      beat_cnt     <= '0;
      frame_len_q  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count        <= count_next;
      in_ready_q   <= (count_next != 2'd2);
      frame_done_q <= pop && mem[rd_ptr][0];
      if (pop) begin
        if (mem[rd_ptr][0]) begin
          frame_len_q <= beat_inc;
          beat_cnt    <= '0;
        end else begin
          beat_cnt <= beat_inc;
        end
      end
    end
  end

  assign io.in_ready   = in_ready_q;
  assign io.out_valid  = (count != 2'd0);
  assign io.out_a      = mem[rd_ptr][64:33];
  assign io.out_b      = mem[rd_ptr][32:1];
  assign io.out_last   = mem[rd_ptr][0];
  assign io.frame_done = frame_done_q;
  assign io.frame_len  = frame_len_q;
endmodule

// File: tb/tb_s_32bit_unfold.sv
// tb/tb_s_32bit_unfold.sv - randomized self-checking bench for s_32bit_unfold against a queue model
module tb_s_32bit_unfold;
  typedef struct packed {
    logic [15:0] aa;
    logic [15:0] ahi;
    logic [15:0] bb;
    logic [15:0] bhi;
    logic        last;
  } beat_t;

  logic clk;
  logic rst_n;

  s_32bit_unfold_if #(.CNT_W(8)) u ();
  s_32bit_unfold_if #(.CNT_W(2)) u2 ();

  s_32bit_unfold #(.CNT_W(8)) dut  (.clk(clk), .rst_n(rst_n), .io(u));
  s_32bit_unfold #(.CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .io(u2));

  assign u2.in_valid  = u.in_valid;
  assign u2.in_aa     = u.in_aa;
  assign u2.in_ahi    = u.in_ahi;
  assign u2.in_bb     = u.in_bb;
  assign u2.in_bhi    = u.in_bhi;
  assign u2.in_last   = u.in_last;
  assign u2.out_ready = u.out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  beat_t       tx[$];
  logic [64:0] q[$];
  int          frame_cnt = 0;
  int          exp_len1  = 0;
  int          exp_len2  = 0;
  logic        exp_fd    = 1'b0;
  int          n_out     = 0;
  int          src_mode  = 0;
  int          sink_mode = 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic beat_t make_beat(input logic last);
    beat_t b;
    b.aa   = 16'($urandom);
    b.ahi  = 16'($urandom);
    b.bb   = 16'($urandom);
    b.bhi  = 16'($urandom);
    b.last = last;
    return b;
  endfunction

  function automatic int min_i(input int x, input int y);
    return (x < y) ? x : y;
  endfunction

  // One clock: drive at posedge+1, check and advance the model at negedge.
  task automatic cycle();
    logic        in_fire;
    logic        out_fire;
    logic [31:0] a;
    logic [31:0] b;
    u.in_valid = (tx.size() > 0) && (src_mode == 0 || $urandom_range(0, 9) < 7);
    if (tx.size() > 0) begin
      u.in_aa   = tx[0].aa;
      u.in_ahi  = tx[0].ahi;
      u.in_bb   = tx[0].bb;
      u.in_bhi  = tx[0].bhi;
      u.in_last = tx[0].last;
    end
    u.out_ready = (sink_mode == 1) || (sink_mode == 2 && $urandom_range(0, 1) == 1);
    @(negedge clk);
    check("in_ready", u.in_ready, q.size() < 2);
    check("out_valid", u.out_valid, q.size() > 0);
    if (q.size() > 0) begin
      check("out_a", u.out_a, q[0][64:33]);
      check("out_b", u.out_b, q[0][32:1]);
      check("out_last", u.out_last, q[0][0]);
      check("out_a_cnt2", u2.out_a, q[0][64:33]);
    end
    check("frame_done", u.frame_done, exp_fd);
    check("frame_len", u.frame_len, exp_len1);
    check("frame_done_cnt2", u2.frame_done, exp_fd);
    check("frame_len_cnt2", u2.frame_len, exp_len2);
    in_fire  = u.in_valid && (q.size() < 2);
    out_fire = (q.size() > 0) && u.out_ready;
    exp_fd   = 1'b0;
    if (out_fire) begin
      n_out++;
      frame_cnt++;
      if (q[0][0]) begin
        exp_fd    = 1'b1;
        exp_len1  = min_i(frame_cnt, 255);
        exp_len2  = min_i(frame_cnt, 3);
        frame_cnt = 0;
      end
      void'(q.pop_front());
    end
    if (in_fire) begin
      a = {tx[0].ahi, tx[0].aa ^ tx[0].ahi};
      b = {tx[0].bhi, tx[0].bb ^ tx[0].bhi};
      q.push_back({a, b, tx[0].last});
      void'(tx.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((tx.size() > 0 || q.size() > 0) && n < limit) begin
      cycle();
      n++;
    end
    check("drain_in_budget", (tx.size() == 0 && q.size() == 0), 1);
  endtask

  initial begin
    beat_t bt;
    int    start;
    int    cyc;

    rst_n       = 1'b0;
    u.in_valid  = 1'b0;
    u.in_aa     = '0;
    u.in_ahi    = '0;
    u.in_bb     = '0;
    u.in_bhi    = '0;
    u.in_last   = 1'b0;
    u.out_ready = 1'b0;
    #2;
    check("rst_in_ready", u.in_ready, 0);
    check("rst_out_valid", u.out_valid, 0);
    check("rst_out_a", u.out_a, 0);
    check("rst_out_b", u.out_b, 0);
    check("rst_out_last", u.out_last, 0);
    check("rst_frame_done", u.frame_done, 0);
    check("rst_frame_len", u.frame_len, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", u.in_ready, 1);

    // Round trip with the known vector
    bt.aa = 16'h6042; bt.ahi = 16'hDEAD; bt.bb = 16'hFFFF; bt.bhi = 16'h1234; bt.last = 1'b0;
    tx.push_back(bt);
    src_mode  = 0;
    sink_mode = 1;
    cycle();
    check("rt_out_valid", u.out_valid, 1);
    check("rt_out_a", u.out_a, 32'hDEADBEEF);
    check("rt_out_b", u.out_b, 32'h1234EDCB);
    cycle();
    check("rt_out_valid_once", u.out_valid, 0);
    cycle();

    // Backpressure: third beat must be held until the sink drains
    for (int i = 0; i < 3; i++) tx.push_back(make_beat(i == 2));
    sink_mode = 0;
    repeat (4) cycle();
    check("bp_in_ready_low", u.in_ready, 0);
    check("bp_third_held", tx.size(), 1);
    start     = n_out;
    sink_mode = 1;
    drain(20);
    check("bp_out_count", n_out - start, 3);

    // 5-beat frame with random backpressure, then a 1-beat frame
    for (int i = 0; i < 5; i++) tx.push_back(make_beat(i == 4));
    src_mode  = 1;
    sink_mode = 2;
    drain(200);
    check("frame5_len", u.frame_len, 5);
    tx.push_back(make_beat(1'b1));
    drain(100);
    check("frame1_len", u.frame_len, 1);

    // Saturation: 6-beat frame reads 6 at CNT_W=8 and 3 at CNT_W=2
    for (int i = 0; i < 6; i++) tx.push_back(make_beat(i == 5));
    drain(200);
    check("sat_len_w8", u.frame_len, 6);
    check("sat_len_w2", u2.frame_len, 3);

    // Consecutive single-beat frames pulse frame_done on consecutive cycles
    src_mode  = 0;
    sink_mode = 1;
    for (int i = 0; i < 3; i++) tx.push_back(make_beat(1'b1));
    drain(50);
    cycle();

    // Streaming 16 beats: one beat per cycle, in_ready stays high
    for (int i = 0; i < 16; i++) tx.push_back(make_beat(i == 15));
    start = n_out;
    cyc   = 0;
    while (n_out - start < 16 && cyc < 100) begin
      cycle();
      cyc++;
    end
    check("stream_cycles", cyc, 17);
    check("stream_len", u.frame_len, 16);

    // Random soak
    src_mode  = 1;
    sink_mode = 2;
    for (int i = 0; i < 40; i++) tx.push_back(make_beat($urandom_range(0, 4) == 0));
    tx.push_back(make_beat(1'b1));
    drain(600);

    // Reset mid-frame: one beat already counted, two beats buffered
    src_mode  = 0;
    sink_mode = 1;
    tx.push_back(make_beat(1'b0));
    cycle();
    cycle();
    sink_mode = 0;
    tx.push_back(make_beat(1'b0));
    tx.push_back(make_beat(1'b1));
    repeat (3) cycle();
    check("mid_buffered", q.size(), 2);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", u.out_valid, 0);
    check("mid_rst_in_ready", u.in_ready, 0);
    check("mid_rst_out_a", u.out_a, 0);
    check("mid_rst_frame_len", u.frame_len, 0);
    q.delete();
    tx.delete();
    frame_cnt   = 0;
    exp_fd      = 1'b0;
    exp_len1    = 0;
    exp_len2    = 0;
    u.in_valid  = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("mid_post_in_ready", u.in_ready, 1);
    sink_mode = 1;
    repeat (3) cycle();
    tx.push_back(make_beat(1'b0));
    tx.push_back(make_beat(1'b1));
    drain(50);
    check("mid_new_frame_len", u.frame_len, 2);
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
